// File: rtl/refresh_cmd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : refresh_cmd_arbiter_pkg
//  Purpose  : Shared FSM encodings, payload width defaults, command strobe bit
//             order and guard-load helper for the refresh command arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package refresh_cmd_arbiter_pkg;

    // Arbiter FSM encodings
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_DRAIN = 2'd1,
        ARB_GRANT = 2'd2
    } arb_state_e;

    // Default payload widths (match the refresher cmd_payload_a / ba)
    localparam int ARB_AW_DEFAULT = 17;
    localparam int ARB_BW_DEFAULT = 3;

    // Command strobe vector bit order: {cas, ras, we}
    localparam int CMD_CAS_BIT = 2;
    localparam int CMD_RAS_BIT = 1;
    localparam int CMD_WE_BIT  = 0;

    // Guard counter load value: a zero guard is treated as one idle cycle
    function automatic logic [7:0] guard_load_value(input int unsigned cycles);
        int unsigned eff;
        eff = (cycles == 0) ? 1 : cycles;
        return 8'(eff - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/refresh_cmd_arbiter_guard_counter.sv
`default_nettype none
// ============================================================================
//  Module   : arb_guard_counter
//  Purpose  : Loadable down-counter with zero flag. Counts down once per dec_i
//             cycle and sticks at zero.
//  Revision : 1.0 - initial release
// ============================================================================
module arb_guard_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] count_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    // Load has priority over decrement; decrement saturates at zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/refresh_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : refresh_cmd_arbiter
//  Purpose  : Merges refresher and bank-machine command streams into a single
//             registered PHY command slot. Refresh has absolute priority:
//             normal traffic is blocked, a guard interval elapses, then the
//             refresher is granted until it signals ref_last.
//  Options  : REFRESH_STATS_EN adds stat_ref_count / stat_max_wait ports.
//  Revision : 1.0 - initial release
// ============================================================================
module refresh_cmd_arbiter
    import refresh_cmd_arbiter_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int          AW           = ARB_AW_DEFAULT,
    parameter int          BW           = ARB_BW_DEFAULT
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    // refresher side
    input  logic          ref_valid,
    output logic          ref_ready,
    input  logic          ref_last,
    input  logic [AW-1:0] ref_a,
    input  logic [BW-1:0] ref_ba,
    input  logic          ref_cas,
    input  logic          ref_ras,
    input  logic          ref_we,
    // normal bank-machine side
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_a,
    input  logic [BW-1:0] req_ba,
    input  logic          req_cas,
    input  logic          req_ras,
    input  logic          req_we,
    // registered PHY command slot
    output logic          phy_cs,
    output logic [AW-1:0] phy_a,
    output logic [BW-1:0] phy_ba,
    output logic          phy_cas,
    output logic          phy_ras,
    output logic          phy_we,
    output logic          refresh_active
`ifdef REFRESH_STATS_EN
    ,
    output logic [15:0]   stat_ref_count,
    output logic [7:0]    stat_max_wait
`endif
);

    localparam logic [7:0] c_GUARD_LOAD = guard_load_value(GUARD_CYCLES);

    arb_state_e    state_q;
    logic          phy_cs_q;
    logic [AW-1:0] phy_a_q;
    logic [BW-1:0] phy_ba_q;
    logic [2:0]    phy_strb_q;

    logic [2:0]    ref_strb;
    logic [2:0]    req_strb;
    logic          req_accept;
    logic          guard_load;
    logic          guard_zero;
    logic [7:0]    guard_cnt_unused;   // FSM only needs the zero flag

    assign ref_strb = {ref_cas, ref_ras, ref_we};
    assign req_strb = {req_cas, req_ras, req_we};

    // Handshakes decode straight from the registered state; req_ready is also
    // forced low while reset is held so nothing is accepted during reset.
    assign req_ready      = sys_rst_n && (state_q == ARB_IDLE) && !ref_valid;
    assign ref_ready      = (state_q == ARB_GRANT);
    assign refresh_active = (state_q == ARB_DRAIN) || (state_q == ARB_GRANT);
    assign req_accept     = req_valid && req_ready;
    assign guard_load     = (state_q == ARB_IDLE) && ref_valid;

    arb_guard_counter #(.WIDTH(8)) u_guard (
        .clk_i      (sys_clk),
        .rst_ni     (sys_rst_n),
        .load_i     (guard_load),
        .load_val_i (c_GUARD_LOAD),
        .dec_i      (state_q == ARB_DRAIN),
        .count_o    (guard_cnt_unused),
        .zero_o     (guard_zero)
    );

    // Arbiter FSM and PHY output register: strobes default to NOP each cycle,
    // address/bank hold their last value unless a new command is launched.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ARB_IDLE;
            phy_cs_q   <= 1'b0;
            phy_a_q    <= '0;
            phy_ba_q   <= '0;
            phy_strb_q <= 3'b000;
        end else begin
            phy_cs_q   <= 1'b0;
            phy_strb_q <= 3'b000;
            case (state_q)
                ARB_IDLE: begin
                    if (ref_valid) begin
                        state_q <= ARB_DRAIN;
                    end else if (req_accept) begin
                        phy_cs_q   <= 1'b1;
                        phy_a_q    <= req_a;
                        phy_ba_q   <= req_ba;
                        phy_strb_q <= req_strb;
                    end
                end
                ARB_DRAIN: begin
                    if (!ref_valid) begin
                        state_q <= ARB_IDLE;
                    end else if (guard_zero) begin
                        state_q <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    // refresher NOP cycles leave the slot empty
                    if (|ref_strb) begin
                        phy_cs_q   <= 1'b1;
                        phy_a_q    <= ref_a;
                        phy_ba_q   <= ref_ba;
                        phy_strb_q <= ref_strb;
                    end
                    if (ref_last) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign phy_cs  = phy_cs_q;
    assign phy_a   = phy_a_q;
    assign phy_ba  = phy_ba_q;
    assign phy_cas = phy_strb_q[CMD_CAS_BIT];
    assign phy_ras = phy_strb_q[CMD_RAS_BIT];
    assign phy_we  = phy_strb_q[CMD_WE_BIT];

`ifdef REFRESH_STATS_EN
    logic [15:0] stat_ref_count_q;
    logic [7:0]  stat_max_wait_q;
    logic [7:0]  wait_cnt;
    logic        wait_zero;
    logic [8:0]  wait_sum;
    logic [7:0]  wait_meas;
    logic        grant_enter;

    // Counts down from 0xFF through DRAIN; elapsed drain cycles = ~count + 1,
    // plus the IDLE cycle in which ref_valid was seen gives the grant latency.
    arb_guard_counter #(.WIDTH(8)) u_wait (
        .clk_i      (sys_clk),
        .rst_ni     (sys_rst_n),
        .load_i     (guard_load),
        .load_val_i (8'hFF),
        .dec_i      ((state_q == ARB_DRAIN) && !wait_zero),
        .count_o    (wait_cnt),
        .zero_o     (wait_zero)
    );

    assign grant_enter = (state_q == ARB_DRAIN) && ref_valid && guard_zero;
    assign wait_sum    = {1'b0, ~wait_cnt} + 9'd2;
    assign wait_meas   = wait_sum[8] ? 8'hFF : wait_sum[7:0];

    // Saturating refresh counter and worst-case grant latency tracker
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stat_ref_count_q <= '0;
            stat_max_wait_q  <= '0;
        end else begin
            if ((state_q == ARB_GRANT) && ref_last && (stat_ref_count_q != 16'hFFFF)) begin
                stat_ref_count_q <= stat_ref_count_q + 16'd1;
            end
            if (grant_enter && (wait_meas > stat_max_wait_q)) begin
                stat_max_wait_q <= wait_meas;
            end
        end
    end

    assign stat_ref_count = stat_ref_count_q;
    assign stat_max_wait  = stat_max_wait_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_refresh_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_refresh_cmd_arbiter
//  Purpose  : Directed, table-driven bench for refresh_cmd_arbiter
//             (GUARD_CYCLES=4) plus hand sequences for the refresh window,
//             reset during GRANT and the optional statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_refresh_cmd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rv, rl;
    logic [2:0]  rs;            // {cas, ras, we}
    logic [16:0] ra;
    logic [2:0]  rba;
    logic        qv;
    logic [2:0]  qs;
    logic [16:0] qa;
    logic [2:0]  qba;

    logic        ref_ready, req_ready, phy_cs, phy_cas, phy_ras, phy_we, refresh_active;
    logic [16:0] phy_a;
    logic [2:0]  phy_ba;
`ifdef REFRESH_STATS_EN
    logic [15:0] stat_ref_count;
    logic [7:0]  stat_max_wait;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    refresh_cmd_arbiter #(.GUARD_CYCLES(4), .AW(17), .BW(3)) dut (
        .sys_clk        (clk),
        .sys_rst_n      (rst_n),
        .ref_valid      (rv),
        .ref_ready      (ref_ready),
        .ref_last       (rl),
        .ref_a          (ra),
        .ref_ba         (rba),
        .ref_cas        (rs[2]),
        .ref_ras        (rs[1]),
        .ref_we         (rs[0]),
        .req_valid      (qv),
        .req_ready      (req_ready),
        .req_a          (qa),
        .req_ba         (qba),
        .req_cas        (qs[2]),
        .req_ras        (qs[1]),
        .req_we         (qs[0]),
        .phy_cs         (phy_cs),
        .phy_a          (phy_a),
        .phy_ba         (phy_ba),
        .phy_cas        (phy_cas),
        .phy_ras        (phy_ras),
        .phy_we         (phy_we),
        .refresh_active (refresh_active)
`ifdef REFRESH_STATS_EN
        ,
        .stat_ref_count (stat_ref_count),
        .stat_max_wait  (stat_max_wait)
`endif
    );

    typedef struct {
        logic        rv;  logic rl; logic [2:0] rs; logic [16:0] ra; logic [2:0] rba;
        logic        qv;  logic [2:0] qs; logic [16:0] qa; logic [2:0] qba;
        logic        e_qr; logic e_rr; logic e_act; logic e_cs;
        logic [2:0]  e_s; logic [16:0] e_a; logic [2:0] e_ba;
    } vec_t;

    localparam int NVEC = 31;
    vec_t tbl [NVEC];

    function automatic vec_t mk(
        input logic i_rv, input logic i_rl, input logic [2:0] i_rs, input logic [16:0] i_ra,
        input logic [2:0] i_rba, input logic i_qv, input logic [2:0] i_qs, input logic [16:0] i_qa,
        input logic [2:0] i_qba, input logic e_qr, input logic e_rr, input logic e_act,
        input logic e_cs, input logic [2:0] e_s, input logic [16:0] e_a, input logic [2:0] e_ba);
        vec_t v;
        v.rv = i_rv; v.rl = i_rl; v.rs = i_rs; v.ra = i_ra; v.rba = i_rba;
        v.qv = i_qv; v.qs = i_qs; v.qa = i_qa; v.qba = i_qba;
        v.e_qr = e_qr; v.e_rr = e_rr; v.e_act = e_act; v.e_cs = e_cs;
        v.e_s = e_s; v.e_a = e_a; v.e_ba = e_ba;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_snapshot();
        return {5'd0, req_ready, ref_ready, refresh_active, phy_cs,
                phy_cas, phy_ras, phy_we, phy_a, phy_ba};
    endfunction

    // Full refresh window: latency to grant, PRE-ALL, NOP, REF+last, reopen
    task automatic do_refresh(input int idx);
        int lat;
        rv = 1'b1; lat = 0;
        while (ref_ready !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check($sformatf("ref_latency[%0d]", idx), 32'(lat), 32'd5);
        if (ref_ready !== 1'b1) begin
            rv = 1'b0;
            return;
        end
        check($sformatf("grant_active[%0d]", idx), 32'(refresh_active), 32'd1);
        rs = 3'b011; ra = 17'd1024; rba = 3'd0;                 // PRE-ALL
        @(posedge clk); #1;
        check($sformatf("preall_phy[%0d]", idx), {phy_cs, phy_cas, phy_ras, phy_we, 11'd0, phy_a},
              {1'b1, 3'b011, 11'd0, 17'd1024});
        rs = 3'b000; ra = 17'd0;                                // NOP
        @(posedge clk); #1;
        check($sformatf("nop_phy[%0d]", idx), {phy_cs, phy_cas, phy_ras, phy_we}, 32'h0);
        rs = 3'b110; rl = 1'b1;                                 // REF + last
        @(posedge clk); #1;
        rv = 1'b0; rl = 1'b0; rs = 3'b000;
        #1;
        check($sformatf("ref_phy_reopen[%0d]", idx),
              {req_ready, ref_ready, phy_cs, phy_cas, phy_ras, phy_we}, {2'b10, 1'b1, 3'b110});
        @(posedge clk); #1;
    endtask

    initial begin
        int pulses;
        logic [16:0] exp_a;
        logic [2:0]  exp_s, exp_ba;

        // ---------------- vector table ----------------
        //             rv rl rs      ra        rba  qv qs      qa       qba  qr rr act cs s       a         ba
        tbl[0]  = mk(0, 0, 3'b000, 17'h0,    3'd0, 0, 3'b000, 17'h0,   3'd0, 1, 0, 0, 0, 3'b000, 17'h0,    3'd0);
        tbl[1]  = mk(0, 0, 3'b000, 17'h0,    3'd0, 1, 3'b010, 17'h100, 3'd1, 1, 0, 0, 0, 3'b000, 17'h0,    3'd0);
        tbl[2]  = mk(0, 0, 3'b000, 17'h0,    3'd0, 1, 3'b101, 17'h020, 3'd1, 1, 0, 0, 1, 3'b010, 17'h100,  3'd1);
        tbl[3]  = mk(0, 0, 3'b000, 17'h0,    3'd0, 0, 3'b000, 17'h0,   3'd0, 1, 0, 0, 1, 3'b101, 17'h020,  3'd1);
        tbl[4]  = mk(0, 0, 3'b000, 17'h0,    3'd0, 0, 3'b100, 17'h055, 3'd7, 1, 0, 0, 0, 3'b000, 17'h020,  3'd1);
        tbl[5]  = mk(0, 0, 3'b000, 17'h0,    3'd0, 0, 3'b100, 17'h055, 3'd7, 1, 0, 0, 0, 3'b000, 17'h020,  3'd1);
        tbl[6]  = mk(1, 0, 3'b000, 17'h0,    3'd0, 1, 3'b100, 17'h077, 3'd2, 0, 0, 0, 0, 3'b000, 17'h020,  3'd1);
        for (int k = 7; k <= 10; k++)
            tbl[k] = mk(1, 0, 3'b000, 17'h0, 3'd0, 1, 3'b100, 17'h077, 3'd2, 0, 0, 1, 0, 3'b000, 17'h020, 3'd1);
        tbl[11] = mk(1, 0, 3'b011, 17'd1024, 3'd0, 1, 3'b100, 17'h077, 3'd2, 0, 1, 1, 0, 3'b000, 17'h020,  3'd1);
        tbl[12] = mk(1, 0, 3'b000, 17'h0,    3'd0, 1, 3'b100, 17'h077, 3'd2, 0, 1, 1, 1, 3'b011, 17'd1024, 3'd0);
        tbl[13] = mk(1, 0, 3'b000, 17'h0,    3'd0, 1, 3'b100, 17'h077, 3'd2, 0, 1, 1, 0, 3'b000, 17'd1024, 3'd0);
        tbl[14] = mk(1, 1, 3'b110, 17'h0,    3'd0, 1, 3'b100, 17'h077, 3'd2, 0, 1, 1, 0, 3'b000, 17'd1024, 3'd0);
        tbl[15] = mk(0, 0, 3'b000, 17'h0,    3'd0, 1, 3'b010, 17'h033, 3'd4, 1, 0, 0, 1, 3'b110, 17'h0,    3'd0);
        tbl[16] = mk(0, 0, 3'b000, 17'h0,    3'd0, 0, 3'b000, 17'h0,   3'd0, 1, 0, 0, 1, 3'b010, 17'h033,  3'd4);
        tbl[17] = mk(0, 0, 3'b000, 17'h0,    3'd0, 0, 3'b000, 17'h0,   3'd0, 1, 0, 0, 0, 3'b000, 17'h033,  3'd4);
        tbl[18] = mk(1, 0, 3'b000, 17'h0,    3'd0, 0, 3'b000, 17'h0,   3'd0, 0, 0, 0, 0, 3'b000, 17'h033,  3'd4);
        tbl[19] = mk(0, 0, 3'b000, 17'h0,    3'd0, 0, 3'b000, 17'h0,   3'd0, 0, 0, 1, 0, 3'b000, 17'h033,  3'd4);
        tbl[20] = mk(0, 0, 3'b000, 17'h0,    3'd0, 1, 3'b001, 17'h044, 3'd6, 1, 0, 0, 0, 3'b000, 17'h033,  3'd4);
        tbl[21] = mk(0, 0, 3'b000, 17'h0,    3'd0, 0, 3'b000, 17'h0,   3'd0, 1, 0, 0, 1, 3'b001, 17'h044,  3'd6);
        tbl[22] = mk(1, 0, 3'b000, 17'h0,    3'd0, 0, 3'b000, 17'h0,   3'd0, 0, 0, 0, 0, 3'b000, 17'h044,  3'd6);
        for (int k = 23; k <= 26; k++)
            tbl[k] = mk(1, 0, 3'b000, 17'h0, 3'd0, 0, 3'b000, 17'h0, 3'd0, 0, 0, 1, 0, 3'b000, 17'h044, 3'd6);
        tbl[27] = mk(0, 0, 3'b000, 17'h0,    3'd0, 0, 3'b000, 17'h0,   3'd0, 0, 1, 1, 0, 3'b000, 17'h044,  3'd6);
        tbl[28] = mk(0, 0, 3'b000, 17'h0,    3'd0, 0, 3'b000, 17'h0,   3'd0, 0, 1, 1, 0, 3'b000, 17'h044,  3'd6);
        tbl[29] = mk(1, 1, 3'b110, 17'h0,    3'd0, 0, 3'b000, 17'h0,   3'd0, 0, 1, 1, 0, 3'b000, 17'h044,  3'd6);
        tbl[30] = mk(0, 0, 3'b000, 17'h0,    3'd0, 0, 3'b000, 17'h0,   3'd0, 1, 0, 0, 1, 3'b110, 17'h0,    3'd0);

        // ---------------- reset state ----------------
        rst_n = 1'b0; rv = 0; rl = 0; rs = 0; ra = 0; rba = 0;
        qv = 1'b1; qs = 3'b010; qa = 17'h1; qba = 3'd1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_snapshot(), 32'h0);
        qv = 0; qs = 0; qa = 0; qba = 0;
        rst_n = 1'b1;

        // ---------------- table vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            rv = tbl[i].rv; rl = tbl[i].rl; rs = tbl[i].rs; ra = tbl[i].ra; rba = tbl[i].rba;
            qv = tbl[i].qv; qs = tbl[i].qs; qa = tbl[i].qa; qba = tbl[i].qba;
            #4;
            check($sformatf("vec[%0d]", i), dut_snapshot(),
                  {5'd0, tbl[i].e_qr, tbl[i].e_rr, tbl[i].e_act, tbl[i].e_cs,
                   tbl[i].e_s, tbl[i].e_a, tbl[i].e_ba});
            @(posedge clk); #1;
        end
        rv = 0; rl = 0; rs = 0; ra = 0; rba = 0; qv = 0; qs = 0; qa = 0; qba = 0;

        // ---------------- normal-only burst of 10 ----------------
        pulses = 0; exp_a = 0; exp_s = 0; exp_ba = 0;
        for (int i = 0; i < 10; i++) begin
            qv = 1'b1; qs = (i % 2 == 1) ? 3'b101 : 3'b010;
            qa = 17'(i * 7 + 3); qba = 3'(i);
            #1;
            check($sformatf("burst_ready[%0d]", i), 32'(req_ready), 32'd1);
            if (i > 0) begin
                if (phy_cs === 1'b1) pulses++;
                check($sformatf("burst_phy[%0d]", i - 1),
                      {phy_cs, phy_cas, phy_ras, phy_we, phy_ba, 8'd0, phy_a},
                      {1'b1, exp_s, exp_ba, 8'd0, exp_a});
            end
            exp_a = qa; exp_s = qs; exp_ba = qba;
            @(posedge clk); #1;
        end
        qv = 0; qs = 0;
        #1;
        if (phy_cs === 1'b1) pulses++;
        check("burst_phy[9]", {phy_cs, phy_cas, phy_ras, phy_we, phy_ba, 8'd0, phy_a},
              {1'b1, exp_s, exp_ba, 8'd0, exp_a});
        @(posedge clk); #1;
        check("burst_idle_after", 32'(phy_cs), 32'd0);
        check("burst_pulse_count", 32'(pulses), 32'd10);

        // ---------------- reset asserted during GRANT ----------------
        begin
            int lat;
            rv = 1'b1; lat = 0;
            while (ref_ready !== 1'b1 && lat < 40) begin
                @(posedge clk); #1; lat++;
            end
            check("rst_grant_reached", 32'(ref_ready), 32'd1);
            rs = 3'b011; ra = 17'd1024; rba = 3'd0;
            @(posedge clk); #1;
            check("rst_phy_before", 32'(phy_cs), 32'd1);
            #2 rst_n = 1'b0;
            #1;
            check("rst_mid_grant", {req_ready, ref_ready, refresh_active, phy_cs}, 32'h0);
            rv = 0; rs = 0; ra = 0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            qv = 1'b1; qs = 3'b010; qa = 17'h1AB; qba = 3'd3;
            #1;
            check("rst_after_req_ready", {req_ready, ref_ready, refresh_active}, 32'h4);
            @(posedge clk); #1;
            qv = 0; qs = 0;
            check("rst_after_phy", {phy_cs, phy_cas, phy_ras, phy_we, phy_ba, 8'd0, phy_a},
                  {1'b1, 3'b010, 3'd3, 8'd0, 17'h1AB});
            @(posedge clk); #1;
        end

        // ---------------- three full refreshes ----------------
        for (int r = 0; r < 3; r++) do_refresh(r);
`ifdef REFRESH_STATS_EN
        check("stat_ref_count", 32'(stat_ref_count), 32'd3);
        check("stat_max_wait", 32'(stat_max_wait), 32'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Hard time limit so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
